// File: rtl/seq_divider.sv
// Sequential 32-bit signed divider (MIPS div semantics): restoring division, one quotient bit per clock.
// Optional macro DIV_ZERO_EXC_EN: a zero divisor finishes in one edge with div_zero raised.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [32:0] dvs;
  logic [31:0] rem;
  logic [31:0] acc;
  logic        neg_q, neg_r;
  logic        accept, zero_div;
  logic [32:0] abs_a, abs_b, shifted;
  logic        take;

  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
`ifdef DIV_ZERO_EXC_EN
    zero_div = (divisor == '0);
`else
    zero_div = 1'b0;
`endif
    // 33-bit magnitudes keep |0x80000000| exact
    abs_a   = dividend[31] ? (33'd0 - {1'b1, dividend}) : {1'b0, dividend};
    abs_b   = divisor[31]  ? (33'd0 - {1'b1, divisor})  : {1'b0, divisor};
    shifted = {rem, acc[31]};
    take    = (shifted >= dvs);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done      = (state == DONE);
        state_nxt = accept ? (zero_div ? DONE : CALC) : IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (count == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      dvs       <= '0;
      rem       <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept && !zero_div) begin
      count <= '0;
      dvs   <= abs_b;
      rem   <= '0;
      acc   <= 32'(abs_a);
      neg_q <= dividend[31] ^ divisor[31];
      neg_r <= dividend[31];
    end else if (state == CALC) begin
      // acc shifts dividend bits out at the top and quotient bits in at the bottom
      rem   <= take ? 32'(shifted - dvs) : shifted[31:0];
      acc   <= {acc[30:0], take};
      count <= count + 5'd1;
    end else if (state == FIX) begin
      quotient  <= neg_q ? (32'd0 - acc) : acc;
      remainder <= neg_r ? (32'd0 - rem) : rem;
    end
  end

`ifdef DIV_ZERO_EXC_EN
  always_ff @(posedge clk) begin
    if (!reset)             div_zero <= 1'b0;
    else if (accept)        div_zero <= zero_div;
    else if (state == DONE) div_zero <= 1'b0;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; covers default build and DIV_ZERO_EXC_EN build.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int unsigned errors = 0;
  int unsigned checks = 0;

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start at edge N, scramble operands during CALC, check result at N+33
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit inject);
    int unsigned early = 0;
    int unsigned gaps  = 0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    start = 1'b0;
    check({tag, "_busy_n"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 32; i++) begin
      if (inject && i == 5) start = 1'b1;
      dividend = $urandom;
      divisor  = $urandom;
      step();
      start = 1'b0;
      if (done) early++;
      if (!busy) gaps++;
    end
    check({tag, "_early_done"}, early, 32'd0);
    check({tag, "_busy_gaps"}, gaps, 32'd0);
    step();
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);

    reset = 1'b1;
    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div("d1000_3_inj", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);

`ifdef DIV_ZERO_EXC_EN
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd0;
    step();
    start = 1'b0;
    check("dz_done", {31'd0, done}, 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_busy", {31'd0, busy}, 32'd0);
    check("dz_q_hold", quotient, 32'd333);
    check("dz_r_hold", remainder, 32'd1);
    step();
    check("dz_done_clr", {31'd0, done}, 32'd0);
    check("dz_flag_clr", {31'd0, div_zero}, 32'd0);
`else
    run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    run_div("dm20_0", 32'hFFFF_FFEC, 32'd0, 32'd1, 32'hFFFF_FFEC, 1'b0);
    step();
`endif

    // reset lands on the 10th CALC edge
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) step();
    reset = 1'b0;
    step();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    reset = 1'b1;
    run_div("after_rst", 32'd1234567, 32'hFFFF_FFA7, 32'hFFFF_C9D1, 32'd48, 1'b0);

    step();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_q_hold", quotient, 32'hFFFF_C9D1);
    check("idle_r_hold", remainder, 32'd48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port start, input, 1 bit: request a division and capture the operands.
REQ-004 The block SHALL have port dividend, input, 32 bits: signed two's-complement numerator (rs).
REQ-005 The block SHALL have port divisor, input, 32 bits: signed two's-complement denominator (rt).
REQ-006 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-008 The block SHALL have port quotient, output, 32 bits: LO value.
REQ-009 The block SHALL have port remainder, output, 32 bits: HI value.
REQ-010 The block SHALL have port div_zero, output, 1 bit: divide-by-zero flag, valid with done.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, CALC, FIX and DONE.
REQ-012 busy SHALL be 1 in CALC and FIX and 0 otherwise; done SHALL be 1 only in DONE.
REQ-013 A rising edge N with start=1 in IDLE or DONE SHALL latch dividend and divisor, clear the 5-bit iteration counter and enter CALC.
REQ-014 start SHALL be ignored in CALC and FIX, and operand input changes after edge N SHALL have no effect.
REQ-015 CALC SHALL run an unsigned restoring division on |dividend| and |divisor|, retiring one quotient bit per edge for 32 edges (edges N+1..N+32), and SHALL enter FIX on the 32nd of them.
REQ-016 FIX (edge N+33) SHALL negate the quotient when the operand signs differ, SHALL give the remainder the sign of the dividend, SHALL register quotient and remainder, and SHALL enter DONE.
REQ-017 done SHALL be high for exactly the cycle between edges N+33 and N+34.
REQ-018 DONE SHALL go to IDLE on the next edge unless start=1 at that edge, in which case it goes to CALC, so back-to-back operations are allowed.
REQ-019 Quotient and remainder SHALL follow truncation toward zero (MIPS div).
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder (mod 2^32).
REQ-021 quotient and remainder SHALL hold their values until the next FIX or reset.
REQ-022 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000 and remainder=0, with no flag (wrap-around).
REQ-023 Absolute values SHALL be computed in 33-bit width so that |0x80000000| is exact.

Reset
REQ-024 When reset=0 at a rising edge, the FSM SHALL go to IDLE and busy, done, div_zero, quotient, remainder and the counter SHALL all become 0, in any state including mid-CALC.
REQ-025 The first edge with reset=1 SHALL be able to accept start.

Configuration
REQ-026 With macro DIV_ZERO_EXC_EN defined, start with divisor=0 SHALL go IDLE/DONE -> DONE in one edge.
REQ-027 With DIV_ZERO_EXC_EN defined, in that case div_zero=1 during DONE, quotient and remainder keep their previous values, and busy stays 0.
REQ-028 With DIV_ZERO_EXC_EN defined, div_zero SHALL be cleared on leaving DONE.
REQ-029 Without DIV_ZERO_EXC_EN, div_zero SHALL be tied 0 and divisor=0 SHALL run the full 34-cycle sequence.
REQ-030 Without DIV_ZERO_EXC_EN, a divisor=0 operation SHALL give remainder=dividend and quotient=0xFFFFFFFF if dividend>=0, else quotient=0x00000001.

Verification
REQ-031 The bench SHALL cover: start at edge N, 100/7 -> busy from N+1, done at N+33 only, quotient=14, remainder=2.
REQ-032 The bench SHALL cover: -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; and 7/-2 -> quotient=0xFFFFFFFD, remainder=0x1.
REQ-033 The bench SHALL cover: 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
REQ-034 The bench SHALL cover 5/0 with DIV_ZERO_EXC_EN -> done and div_zero at N+1, outputs unchanged.
REQ-035 The bench SHALL cover 5/0 without DIV_ZERO_EXC_EN -> done at N+33, quotient=0xFFFFFFFF, remainder=5.
REQ-036 The bench SHALL cover: reset=0 on the 10th CALC edge -> the next cycle shows busy=0, done=0, quotient=remainder=0; start on the next edge -> a correct result 33 edges later.
REQ-037 The bench SHALL cover: start pulses with new operands during CALC -> ignored, and the result matches the original operands.
